// File: rtl/avalon_rsa_dma.sv
// Avalon-MM DMA front end for a byte-serial RSA core: fetches modulus/exponent/message
// words per job, runs the core, and writes the result word back to memory.
module avalon_rsa_dma #(
  parameter int DATA_W       = 256,
  parameter int ADDR_W       = 32,
  parameter int CORE_TIMEOUT = 65535,
  localparam int NB          = DATA_W / 8,
  localparam int CA_W        = $clog2(NB)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_avm_m0_waitrequest,
  input  logic              i_avm_m0_readdatavalid,
  output logic              o_avm_m0_read,
  output logic              o_avm_m0_write,
  output logic [ADDR_W-1:0] o_avm_m0_address,
  input  logic [DATA_W-1:0] i_avm_m0_readdata,
  output logic [DATA_W-1:0] o_avm_m0_writedata,
  input  logic [2:0]        i_avs_s0_address,
  input  logic              i_avs_s0_read,
  input  logic              i_avs_s0_write,
  input  logic [31:0]       i_avs_s0_writedata,
  output logic [31:0]       o_avs_s0_readdata,
  output logic              o_avs_s0_waitrequest,
  output logic              o_core_we,
  output logic              o_core_oe,
  output logic              o_core_start,
  output logic [1:0]        o_core_reg_sel,
  output logic [CA_W-1:0]   o_core_addr,
  output logic [7:0]        o_core_data_i,
  input  logic [7:0]        i_core_data_o,
  input  logic              i_core_ready,
  output logic              o_irq
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_LOAD, S_START, S_CALC, S_UNLOAD, S_WR, S_NEXT
  } state_t;

  localparam logic [ADDR_W-1:0] NB_A     = ADDR_W'(NB);
  localparam logic [CA_W-1:0]   CA_ONE   = CA_W'(1);
  localparam logic [CA_W-1:0]   CA_LAST  = CA_W'(NB - 1);
  localparam logic [CA_W:0]     CNT_ONE  = (CA_W+1)'(1);
  localparam logic [CA_W:0]     CNT_NB   = (CA_W+1)'(NB);
  localparam logic [CA_W:0]     CNT_LAST = (CA_W+1)'(NB - 1);
  localparam logic [31:0]       TMO_LAST = 32'(CORE_TIMEOUT - 1);

  state_t              r_state;
  logic                r_read, r_write, r_we, r_oe, r_start;
  logic [ADDR_W-1:0]   r_addr, r_src, r_dst, r_rd_ptr, r_wr_ptr;
  logic [DATA_W-1:0]   r_word, r_wbuf;
  logic [1:0]          r_reg_sel, r_k;
  logic [CA_W-1:0]     r_caddr;
  logic [7:0]          r_cdata;
  logic [31:0]         r_rdata, r_tmo;
  logic                r_irq_en, r_busy, r_done, r_err, r_first, r_abort;
  logic [15:0]         r_job_count, r_jobs_done;
  logic [CA_W:0]       r_cnt;

  logic                w_go, w_abort_req, w_quiet;
  logic [1:0]          w_sel;
  logic [CA_W-1:0]     w_nx, w_ub;
  logic [CA_W+2:0]     w_nbit, w_ubit;
  logic [15:0]         w_jd_nx;

  assign w_go        = i_avs_s0_write && (i_avs_s0_address == 3'd0) && i_avs_s0_writedata[0] && !r_busy;
  assign w_abort_req = i_avs_s0_write && (i_avs_s0_address == 3'd0) && i_avs_s0_writedata[2] && r_busy;
  assign w_sel       = (r_k == 2'd0) ? 2'b10 : (r_k == 2'd1) ? 2'b11 : 2'b01;
  assign w_nx        = r_caddr + CA_ONE;
  assign w_ub        = r_cnt[CA_W-1:0] - CA_ONE;
  assign w_nbit      = {w_nx, 3'b000};
  assign w_ubit      = {w_ub, 3'b000};
  assign w_jd_nx     = r_jobs_done + 16'd1;

  // Abort may only land when no master command is held or a read reply is still owed.
  always_comb begin
    w_quiet = 1'b1;
    case (r_state)
      S_RD_REQ:  w_quiet = 1'b0;
      S_RD_WAIT: w_quiet = i_avm_m0_readdatavalid;
      S_WR:      w_quiet = !i_avm_m0_waitrequest;
      default:   w_quiet = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_read <= 1'b0; r_write <= 1'b0; r_we <= 1'b0; r_oe <= 1'b0; r_start <= 1'b0;
      r_addr <= '0; r_src <= '0; r_dst <= '0; r_rd_ptr <= '0; r_wr_ptr <= '0;
      r_word <= '0; r_wbuf <= '0; r_reg_sel <= '0; r_k <= '0; r_caddr <= '0; r_cdata <= '0;
      r_rdata <= '0; r_tmo <= '0; r_irq_en <= 1'b0; r_busy <= 1'b0; r_done <= 1'b0;
      r_err <= 1'b0; r_first <= 1'b0; r_abort <= 1'b0;
      r_job_count <= '0; r_jobs_done <= '0; r_cnt <= '0;
    end else begin
      if (i_avs_s0_read) begin
        case (i_avs_s0_address)
          3'd0:    r_rdata <= {30'd0, r_irq_en, 1'b0};
          3'd1:    r_rdata <= {29'd0, r_err, r_done, r_busy};
          3'd2:    r_rdata <= 32'(r_src);
          3'd3:    r_rdata <= 32'(r_dst);
          3'd4:    r_rdata <= {16'd0, r_job_count};
          3'd5:    r_rdata <= {16'd0, r_jobs_done};
          default: r_rdata <= '0;
        endcase
      end
      if (i_avs_s0_write) begin
        case (i_avs_s0_address)
          3'd0: r_irq_en <= i_avs_s0_writedata[1];
          3'd1: begin
            if (i_avs_s0_writedata[1]) r_done <= 1'b0;
            if (i_avs_s0_writedata[2]) r_err  <= 1'b0;
          end
          3'd2: if (!r_busy) r_src <= ADDR_W'(i_avs_s0_writedata);
          3'd3: if (!r_busy) r_dst <= ADDR_W'(i_avs_s0_writedata);
          3'd4: if (!r_busy) r_job_count <= i_avs_s0_writedata[15:0];
          default: ;
        endcase
      end
      if (w_abort_req) r_abort <= 1'b1;

      if (r_abort && w_quiet && r_state != S_IDLE) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_abort <= 1'b0;
        r_read <= 1'b0; r_write <= 1'b0; r_we <= 1'b0; r_oe <= 1'b0; r_start <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_abort <= 1'b0;
            if (w_go) begin
              r_jobs_done <= '0;
              r_err       <= 1'b0;
              if (r_job_count == 16'd0) begin
                r_done <= 1'b1;
              end else begin
                r_done   <= 1'b0;
                r_busy   <= 1'b1;
                r_rd_ptr <= r_src;
                r_wr_ptr <= r_dst;
                r_k      <= '0;
                r_read   <= 1'b1;
                r_addr   <= r_src;
                r_state  <= S_RD_REQ;
              end
            end
          end
          S_RD_REQ: if (!i_avm_m0_waitrequest) begin
            r_read   <= 1'b0;
            r_rd_ptr <= r_rd_ptr + NB_A;
            r_state  <= S_RD_WAIT;
          end
          S_RD_WAIT: if (i_avm_m0_readdatavalid) begin
            r_word    <= i_avm_m0_readdata;
            r_we      <= 1'b1;
            r_caddr   <= '0;
            r_cdata   <= i_avm_m0_readdata[7:0];
            r_reg_sel <= w_sel;
            r_state   <= S_LOAD;
          end
          S_LOAD: begin
            if (r_caddr == CA_LAST) begin
              r_we    <= 1'b0;
              r_caddr <= '0;
              if (r_k == 2'd2) begin
                r_start <= 1'b1;
                r_state <= S_START;
              end else begin
                r_k     <= r_k + 2'd1;
                r_read  <= 1'b1;
                r_addr  <= r_rd_ptr;
                r_state <= S_RD_REQ;
              end
            end else begin
              r_caddr <= w_nx;
              r_cdata <= r_word[w_nbit +: 8];
            end
          end
          S_START: begin
            r_start <= 1'b0;
            r_tmo   <= '0;
            r_first <= 1'b1;
            r_state <= S_CALC;
          end
          S_CALC: begin
            r_first <= 1'b0;
            // A ready still high from the previous operation is ignored right after start.
            if (i_core_ready && !r_first) begin
              r_oe    <= 1'b1;
              r_caddr <= '0;
              r_cnt   <= '0;
              r_state <= S_UNLOAD;
            end else if (r_tmo == TMO_LAST) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_tmo <= r_tmo + 32'd1;
            end
          end
          S_UNLOAD: begin
            // Core output lags the address by one cycle, so byte cnt-1 lands now.
            if (r_cnt != '0) r_wbuf[w_ubit +: 8] <= i_core_data_o;
            if (r_cnt == CNT_NB) begin
              r_write <= 1'b1;
              r_addr  <= r_wr_ptr;
              r_state <= S_WR;
            end else begin
              r_cnt   <= r_cnt + CNT_ONE;
              r_caddr <= w_nx;
              r_oe    <= (r_cnt != CNT_LAST);
            end
          end
          S_WR: if (!i_avm_m0_waitrequest) begin
            r_write  <= 1'b0;
            r_wr_ptr <= r_wr_ptr + NB_A;
            r_state  <= S_NEXT;
          end
          S_NEXT: begin
            r_jobs_done <= w_jd_nx;
            if (w_jd_nx == r_job_count) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_k     <= '0;
              r_read  <= 1'b1;
              r_addr  <= r_rd_ptr;
              r_state <= S_RD_REQ;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_avm_m0_read        = r_read;
  assign o_avm_m0_write       = r_write;
  assign o_avm_m0_address     = r_addr;
  assign o_avm_m0_writedata   = r_wbuf;
  assign o_avs_s0_readdata    = r_rdata;
  assign o_avs_s0_waitrequest = 1'b0;
  assign o_core_we            = r_we;
  assign o_core_oe            = r_oe;
  assign o_core_start         = r_start;
  assign o_core_reg_sel       = r_reg_sel;
  assign o_core_addr          = r_caddr;
  assign o_core_data_i        = r_cdata;
  assign o_irq                = (r_done | r_err) & r_irq_en;

endmodule

// File: tb/tb_avalon_rsa_dma.sv
// Directed bench: 256-bit instance (timeout 100) with random bus stalls, plus a 64-bit instance.
module tb_avalon_rsa_dma;
  localparam int NBA = 32;
  localparam logic [255:0] PAT = {32{8'h5A}};

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  logic [2:0]  s_addr = '0;
  logic [31:0] s_wdata = '0;
  logic        s_rd_a = 0, s_wr_a = 0, s_rd_b = 0, s_wr_b = 0;

  logic wait_a = 0, rdv_a = 0, read_a, write_a, swait_a, we_a, oe_a, start_a, irq_a;
  logic [31:0] addr_a, sdo_a;
  logic [255:0] rdata_a = '0, wdata_a;
  logic [1:0] sel_a; logic [4:0] caddr_a; logic [7:0] cdi_a, cdo_a = '0;
  logic ready_a = 1'b1;

  logic wait_b = 0, rdv_b = 0, read_b, write_b, swait_b, we_b, oe_b, start_b, irq_b;
  logic [31:0] addr_b, sdo_b;
  logic [63:0] rdata_b = '0, wdata_b;
  logic [1:0] sel_b; logic [2:0] caddr_b; logic [7:0] cdi_b, cdo_b = '0;

  avalon_rsa_dma #(.DATA_W(256), .ADDR_W(32), .CORE_TIMEOUT(100)) dut_a (
    .i_clk(clk), .i_reset(rst_n),
    .i_avm_m0_waitrequest(wait_a), .i_avm_m0_readdatavalid(rdv_a),
    .o_avm_m0_read(read_a), .o_avm_m0_write(write_a), .o_avm_m0_address(addr_a),
    .i_avm_m0_readdata(rdata_a), .o_avm_m0_writedata(wdata_a),
    .i_avs_s0_address(s_addr), .i_avs_s0_read(s_rd_a), .i_avs_s0_write(s_wr_a),
    .i_avs_s0_writedata(s_wdata), .o_avs_s0_readdata(sdo_a), .o_avs_s0_waitrequest(swait_a),
    .o_core_we(we_a), .o_core_oe(oe_a), .o_core_start(start_a), .o_core_reg_sel(sel_a),
    .o_core_addr(caddr_a), .o_core_data_i(cdi_a), .i_core_data_o(cdo_a),
    .i_core_ready(ready_a), .o_irq(irq_a));

  avalon_rsa_dma #(.DATA_W(64), .ADDR_W(32)) dut_b (
    .i_clk(clk), .i_reset(rst_n),
    .i_avm_m0_waitrequest(wait_b), .i_avm_m0_readdatavalid(rdv_b),
    .o_avm_m0_read(read_b), .o_avm_m0_write(write_b), .o_avm_m0_address(addr_b),
    .i_avm_m0_readdata(rdata_b), .o_avm_m0_writedata(wdata_b),
    .i_avs_s0_address(s_addr), .i_avs_s0_read(s_rd_b), .i_avs_s0_write(s_wr_b),
    .i_avs_s0_writedata(s_wdata), .o_avs_s0_readdata(sdo_b), .o_avs_s0_waitrequest(swait_b),
    .o_core_we(we_b), .o_core_oe(oe_b), .o_core_start(start_b), .o_core_reg_sel(sel_b),
    .o_core_addr(caddr_b), .o_core_data_i(cdi_b), .i_core_data_o(cdo_b),
    .i_core_ready(1'b1), .o_irq(irq_b));

  // Source memory content: byte i of the word at address a is a[7:0] ^ (7i+1).
  function automatic logic [255:0] mkw(input logic [31:0] a);
    logic [255:0] w;
    for (int i = 0; i < 32; i++) w[8*i +: 8] = a[7:0] ^ 8'(i*7 + 1);
    return w;
  endfunction

  // ---------------- instance A models ----------------
  logic rnd_a = 0, hold_a = 0, pend_a = 0, tc_on = 0;
  int dly_a = 0, we_run_a = 0, last_run_a = 0, starts_a = 0, strobes_a = 0, tcnt = 0;
  logic [255:0] pdat_a;
  logic [31:0] rd_q_a[$], wa_q_a[$];
  logic [255:0] wd_q_a[$];
  logic [1:0] selq_a[$];
  logic [7:0] msg_a [NBA];

  always @(negedge clk) wait_a = hold_a | (rnd_a && ($urandom_range(0, 1) == 1));

  always @(posedge clk) begin
    rdv_a <= 1'b0;
    if (pend_a) begin
      if (dly_a == 0) begin rdv_a <= 1'b1; rdata_a <= pdat_a; pend_a = 0; end
      else dly_a--;
    end
    if (read_a && !wait_a) begin
      rd_q_a.push_back(addr_a); pend_a = 1; pdat_a = mkw(addr_a);
      dly_a = rnd_a ? int'($urandom_range(0, 7)) : 0;
    end
    if (write_a && !wait_a) begin wa_q_a.push_back(addr_a); wd_q_a.push_back(wdata_a); end
    if (read_a || write_a) strobes_a++;
    if (we_a && sel_a == 2'b01) msg_a[caddr_a] <= cdi_a;
    if (we_a && caddr_a == 5'd0) selq_a.push_back(sel_a);
    if (oe_a) cdo_a <= msg_a[caddr_a] ^ 8'h5A;
    if (we_a) we_run_a++;
    else if (we_run_a != 0) begin last_run_a = we_run_a; we_run_a = 0; end
    if (start_a) begin starts_a++; tc_on = 1; tcnt = 0; end
    else if (tc_on && !irq_a) tcnt++;
  end

  // ---------------- instance B models ----------------
  logic pend_b = 0;
  logic [63:0] pdat_b;
  logic [31:0] rd_q_b[$], wa_q_b[$];
  logic [63:0] wd_q_b[$];
  logic [7:0] msg_b [8];
  logic [7:0] seen_b = '0;
  int starts_b = 0;

  always @(posedge clk) begin
    rdv_b <= 1'b0;
    if (pend_b) begin rdv_b <= 1'b1; rdata_b <= pdat_b; pend_b = 0; end
    if (read_b && !wait_b) begin rd_q_b.push_back(addr_b); pend_b = 1; pdat_b = 64'(mkw(addr_b)); end
    if (write_b && !wait_b) begin wa_q_b.push_back(addr_b); wd_q_b.push_back(wdata_b); end
    if (we_b && sel_b == 2'b01) msg_b[caddr_b] <= cdi_b;
    if (we_b) seen_b[caddr_b] = 1'b1;
    if (oe_b) cdo_b <= msg_b[caddr_b] ^ 8'h5A;
    if (start_b) starts_b++;
  end

  // ---------------- check and CSR helpers ----------------
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic csr_wr(input bit b, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk); s_addr = a; s_wdata = d;
    if (b) s_wr_b = 1'b1; else s_wr_a = 1'b1;
    @(negedge clk); s_wr_a = 1'b0; s_wr_b = 1'b0;
  endtask

  task automatic csr_rd(input bit b, input logic [2:0] a, output logic [31:0] d);
    @(negedge clk); s_addr = a;
    if (b) s_rd_b = 1'b1; else s_rd_a = 1'b1;
    @(negedge clk); s_rd_a = 1'b0; s_rd_b = 1'b0;
    d = b ? sdo_b : sdo_a;
  endtask

  task automatic wait_idle(input bit b, input string tag);
    logic [31:0] st;
    logic to;
    to = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      csr_rd(b, 3'd1, st);
      if (!st[0]) begin to = 1'b0; break; end
    end
    chk({tag, "_idle_timeout"}, to, 1'b0);
  endtask

  task automatic clr_a();
    rd_q_a.delete(); wa_q_a.delete(); wd_q_a.delete(); selq_a.delete();
    starts_a = 0; strobes_a = 0; tc_on = 0;
  endtask

  logic [31:0] rv;

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_read", read_a, 1'b0);
    chk("rst_write", write_a, 1'b0);
    chk("rst_addr", addr_a, 32'h0);
    chk("rst_core", {we_a, oe_a, start_a, sel_a, caddr_a}, '0);
    chk("rst_irq", irq_a, 1'b0);
    chk("rst_sdo", sdo_a, 32'h0);
    chk("rst_swait", {swait_a, swait_b}, 2'b00);
    rst_n = 1'b1;
    csr_rd(0, 3'd1, rv); chk("rst_status", rv, 32'h0);

    // JOB_COUNT=0 -> done right away, no traffic
    csr_wr(0, 3'd4, 32'd0);
    clr_a();
    csr_wr(0, 3'd0, 32'h1);
    csr_rd(0, 3'd1, rv); chk("jc0_status", rv, 32'h2);
    csr_rd(0, 3'd5, rv); chk("jc0_jobsdone", rv, 32'h0);
    chk("jc0_strobes", strobes_a, 0);
    csr_wr(0, 3'd1, 32'h2);
    csr_rd(0, 3'd1, rv); chk("w1c_done", rv, 32'h0);

    // single job, 256-bit
    csr_wr(0, 3'd2, 32'h0);
    csr_wr(0, 3'd3, 32'h1000);
    csr_wr(0, 3'd4, 32'd1);
    csr_rd(0, 3'd3, rv); chk("dst_rb", rv, 32'h1000);
    clr_a();
    csr_wr(0, 3'd0, 32'h3);
    wait_idle(0, "j1");
    csr_rd(0, 3'd1, rv); chk("j1_status", rv, 32'h2);
    csr_rd(0, 3'd5, rv); chk("j1_jobsdone", rv, 32'h1);
    chk("j1_irq", irq_a, 1'b1);
    chk("j1_nrd", rd_q_a.size(), 3);
    chk("j1_rd1", rd_q_a[1], 32'h20);
    chk("j1_rd2", rd_q_a[2], 32'h40);
    chk("j1_sel", {selq_a[0], selq_a[1], selq_a[2]}, 6'b10_11_01);
    chk("j1_werun", last_run_a, NBA);
    chk("j1_starts", starts_a, 1);
    chk("j1_nwr", wa_q_a.size(), 1);
    chk("j1_wa", wa_q_a[0], 32'h1000);
    chk("j1_wd_b0", wd_q_a[0][7:0], 8'h1B);
    chk("j1_wd", wd_q_a[0], mkw(32'h40) ^ PAT);
    csr_wr(0, 3'd1, 32'h2);
    chk("j1_irq_clr", irq_a, 1'b0);

    // three jobs with random stalls and read latency
    csr_wr(0, 3'd4, 32'd3);
    clr_a();
    rnd_a = 1'b1;
    csr_wr(0, 3'd0, 32'h3);
    wait_idle(0, "j3");
    rnd_a = 1'b0;
    csr_rd(0, 3'd5, rv); chk("j3_jobsdone", rv, 32'h3);
    chk("j3_nrd", rd_q_a.size(), 9);
    for (int i = 0; i < 9 && i < rd_q_a.size(); i++)
      chk($sformatf("j3_rd%0d", i), rd_q_a[i], 32'(i * 32));
    chk("j3_nwr", wa_q_a.size(), 3);
    for (int i = 0; i < 3 && i < wa_q_a.size(); i++) begin
      chk($sformatf("j3_wa%0d", i), wa_q_a[i], 32'h1000 + 32'(i * 32));
      chk($sformatf("j3_wd%0d", i), wd_q_a[i], mkw(32'((3*i + 2) * 32)) ^ PAT);
    end
    csr_wr(0, 3'd1, 32'h2);

    // core never ready -> timeout after 100 CALC cycles
    ready_a = 1'b0;
    csr_wr(0, 3'd4, 32'd1);
    clr_a();
    csr_wr(0, 3'd0, 32'h3);
    wait_idle(0, "tmo");
    csr_rd(0, 3'd1, rv); chk("tmo_status", rv, 32'h4);
    chk("tmo_cycles", tcnt, 100);
    chk("tmo_irq", irq_a, 1'b1);
    chk("tmo_nwr", wa_q_a.size(), 0);
    csr_wr(0, 3'd1, 32'h4);
    ready_a = 1'b1;

    // abort while a read is stalled
    hold_a = 1'b1;
    clr_a();
    csr_wr(0, 3'd0, 32'h1);
    repeat (5) @(negedge clk);
    chk("ab_read_held", {read_a, addr_a}, {1'b1, 32'h0});
    csr_rd(0, 3'd1, rv); chk("ab_busy", rv, 32'h1);
    csr_wr(0, 3'd2, 32'h777);
    csr_wr(0, 3'd0, 32'h4);
    repeat (4) @(negedge clk);
    chk("ab_still_held", read_a, 1'b1);
    hold_a = 1'b0;
    wait_idle(0, "ab");
    csr_rd(0, 3'd1, rv); chk("ab_status", rv, 32'h0);
    chk("ab_nrd", rd_q_a.size(), 1);
    chk("ab_nwr", wa_q_a.size(), 0);
    chk("ab_quiet", {read_a, write_a, we_a, oe_a, start_a}, 5'b0);
    csr_rd(0, 3'd2, rv); chk("ab_src_kept", rv, 32'h0);
    csr_rd(0, 3'd6, rv); chk("csr6_zero", rv, 32'h0);

    // 64-bit instance single job
    csr_wr(1, 3'd2, 32'h0);
    csr_wr(1, 3'd3, 32'h1000);
    csr_wr(1, 3'd4, 32'd1);
    csr_wr(1, 3'd0, 32'h1);
    wait_idle(1, "b");
    csr_rd(1, 3'd1, rv); chk("b_status", rv, 32'h2);
    csr_rd(1, 3'd5, rv); chk("b_jobsdone", rv, 32'h1);
    chk("b_rd", {rd_q_b[0], rd_q_b[1], rd_q_b[2]}, {32'h0, 32'h8, 32'h10});
    chk("b_caddr_span", seen_b, 8'hFF);
    chk("b_starts", starts_b, 1);
    chk("b_wa", wa_q_b[0], 32'h1000);
    chk("b_wd_b01", wd_q_b[0][15:0], 16'h424B);
    chk("b_wd", wd_q_b[0], 64'(mkw(32'h10)) ^ 64'h5A5A5A5A5A5A5A5A);
    chk("b_irq", irq_b, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
